// File: rtl/song_sequencer_if.sv
// song_sequencer_if: ROM read port and correct-note producer bundle
// master (sequencer): drives rom_addr, correct_note, note_start, note_active, note_index; reads rom_data
// slave  (ROM / score updater): reads the note side, returns rom_data {note[15:12], duration[11:0]}
interface song_sequencer_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [3:0]        correct_note;
  logic              note_start;
  logic              note_active;
  logic [ADDR_W-1:0] note_index;
  modport master (output rom_addr, correct_note, note_start, note_active, note_index, input rom_data);
  modport slave  (input rom_addr, correct_note, note_start, note_active, note_index, output rom_data);
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: plays {note, duration} entries from a 1-cycle-latency song ROM, paced by tempo ticks
// clk, reset_n (async, active-low); start pulse, pause level, tick tempo enable
// bus: ROM address/data plus correct_note, note_start, note_active, note_index
// busy: song in progress; song_done: level until the next start
module song_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic               tick,
  song_sequencer_if.master   bus,
  output logic               busy,
  output logic               song_done
);
  localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, DONE} state_t;
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr, nxt_addr, idx, nxt_idx;
  logic [11:0]       dur, nxt_dur;
  logic [GW-1:0]     gap, nxt_gap;
  logic [3:0]        note, nxt_note;
  logic              ns, nxt_ns;
  logic [3:0]        rom_note;
  logic [11:0]       rom_dur;
  logic              step, last;
  assign rom_note = bus.rom_data[15:12];
  assign rom_dur  = bus.rom_data[11:0];
  assign step     = tick && !pause;
  assign last     = addr == '1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      idx   <= '0;
      dur   <= '0;
      gap   <= '0;
      note  <= '0;
      ns    <= 1'b0;
    end else begin
      state <= nxt;
      addr  <= nxt_addr;
      idx   <= nxt_idx;
      dur   <= nxt_dur;
      gap   <= nxt_gap;
      note  <= nxt_note;
      ns    <= nxt_ns;
    end
  end
  // The end of a note (or of its gap) advances to the next entry; the last
  // address finishes the song instead of wrapping.
  always_comb begin
    nxt      = state;
    nxt_addr = addr;
    nxt_idx  = idx;
    nxt_dur  = dur;
    nxt_gap  = gap;
    nxt_note = note;
    nxt_ns   = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) begin
        nxt      = FETCH;
        nxt_addr = '0;
      end
      FETCH: nxt = WAIT;
      WAIT: if (rom_dur == 12'd0) nxt = DONE;
      else begin
        nxt      = PLAY;
        nxt_dur  = rom_dur;
        nxt_idx  = addr;
        nxt_note = (rom_note == 4'd6 || rom_note > 4'd13) ? 4'd0 : rom_note;
        nxt_ns   = 1'b1;
      end
      PLAY: if (step) begin
        nxt_dur = dur - 12'd1;
        if (dur == 12'd1) begin
          nxt_note = 4'd0;
          if (GAP_TICKS > 0) begin
            nxt     = GAP;
            nxt_gap = GW'(GAP_TICKS);
          end else begin
            nxt      = last ? DONE : FETCH;
            nxt_addr = last ? addr : addr + 1'b1;
          end
        end
      end
      GAP: if (step) begin
        nxt_gap = gap - GW'(1);
        if (gap == GW'(1)) begin
          nxt      = last ? DONE : FETCH;
          nxt_addr = last ? addr : addr + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  assign bus.rom_addr     = addr;
  assign bus.correct_note = note;
  assign bus.note_start   = ns;
  assign bus.note_active  = state == PLAY;
  assign bus.note_index   = idx;
  assign busy             = state == FETCH || state == WAIT || state == PLAY || state == GAP;
  assign song_done        = state == DONE;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: two sequencer instances (gap 2 / 8-bit addr, gap 0 / 2-bit addr) against a procedural song model
module tb_song_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic pause_req = 1'b0, clr_mon = 1'b0;
  int   tick_mode = 0, cyc = 0;
  int   compared = 0, mismatched = 0;
  always #5 clk = ~clk;

  song_sequencer_if #(.ADDR_W(8)) bus_a ();
  song_sequencer_if #(.ADDR_W(2)) bus_b ();
  logic busy_a, done_a, busy_b, done_b;
  song_sequencer #(.ADDR_W(8), .GAP_TICKS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .tick(tick),
    .bus(bus_a), .busy(busy_a), .song_done(done_a));
  song_sequencer #(.ADDR_W(2), .GAP_TICKS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .tick(tick),
    .bus(bus_b), .busy(busy_b), .song_done(done_b));

  logic [15:0] rom [2][256];
  always @(posedge clk) begin
    bus_a.rom_data <= rom[0][bus_a.rom_addr];
    bus_b.rom_data <= rom[1][{6'd0, bus_b.rom_addr}];
  end

  logic [3:0] a_note [2];
  logic       a_ns [2], a_act [2], a_busy [2], a_done [2];
  logic [7:0] a_idx [2], a_addr [2];
  assign a_note[0] = bus_a.correct_note;
  assign a_note[1] = bus_b.correct_note;
  assign a_ns[0]   = bus_a.note_start;
  assign a_ns[1]   = bus_b.note_start;
  assign a_act[0]  = bus_a.note_active;
  assign a_act[1]  = bus_b.note_active;
  assign a_busy[0] = busy_a;
  assign a_busy[1] = busy_b;
  assign a_done[0] = done_a;
  assign a_done[1] = done_b;
  assign a_idx[0]  = bus_a.note_index;
  assign a_idx[1]  = {6'd0, bus_b.note_index};
  assign a_addr[0] = bus_a.rom_addr;
  assign a_addr[1] = {6'd0, bus_b.rom_addr};

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the song as a sequence of waits on clock edges.
  logic [3:0] e_note [2];
  logic       e_ns [2], e_act [2], e_busy [2], e_done [2];
  logic [7:0] e_idx [2], e_addr [2];

  function automatic logic [3:0] map_note(logic [3:0] n);
    return (n == 4'd6 || n > 4'd13) ? 4'd0 : n;
  endfunction

  task automatic clear_exp(int id);
    e_note[id] = 0; e_ns[id] = 0; e_act[id] = 0; e_busy[id] = 0;
    e_done[id] = 0; e_idx[id] = 0; e_addr[id] = 0;
  endtask

  task automatic play(int id, int gap, int aw);
    int addr, rem, g;
    logic [15:0] w;
    bit fin;
    forever begin
      do @(posedge clk); while (!start);
      addr = 0;
      e_addr[id] = 0; e_busy[id] = 1; e_done[id] = 0;
      fin = 0;
      while (!fin) begin
        @(posedge clk);
        @(posedge clk);
        w = rom[id][addr];
        if (w[11:0] == 12'd0) fin = 1;
        else begin
          e_note[id] = map_note(w[15:12]); e_ns[id] = 1; e_act[id] = 1; e_idx[id] = 8'(addr);
          rem = int'(w[11:0]);
          while (rem > 0) begin
            @(posedge clk);
            e_ns[id] = 0;
            if (tick && !pause) rem--;
          end
          e_note[id] = 0; e_act[id] = 0;
          g = gap;
          while (g > 0) begin
            @(posedge clk);
            if (tick && !pause) g--;
          end
          if (addr == (1 << aw) - 1) fin = 1;
          else begin
            addr++;
            e_addr[id] = 8'(addr);
          end
        end
      end
      e_busy[id] = 0; e_done[id] = 1;
    end
  endtask

  task automatic run_model(int id, int gap, int aw);
    forever begin
      clear_exp(id);
      wait (reset_n);
      fork
        play(id, gap, aw);
        @(negedge reset_n);
      join_any
      disable fork;
    end
  endtask

  initial fork
    run_model(0, 2, 8);
    run_model(1, 0, 2);
  join

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("note%0d", i), a_note[i], e_note[i]);
      chk($sformatf("note_start%0d", i), a_ns[i], e_ns[i]);
      chk($sformatf("note_active%0d", i), a_act[i], e_act[i]);
      chk($sformatf("busy%0d", i), a_busy[i], e_busy[i]);
      chk($sformatf("song_done%0d", i), a_done[i], e_done[i]);
      chk($sformatf("note_index%0d", i), a_idx[i], e_idx[i]);
      chk($sformatf("rom_addr%0d", i), a_addr[i], e_addr[i]);
    end

  // Monitor for the literal checks: pulse counts, index log, effective ticks per note.
  int         ns_cnt [2];
  int         nz [2];
  int         eff [2][16];
  logic [7:0] idx_log [2][16];
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (clr_mon) begin
        ns_cnt[i] = 0;
        nz[i] = 0;
        for (int k = 0; k < 16; k++) begin
          eff[i][k] = 0;
          idx_log[i][k] = 8'hff;
        end
      end else begin
        if (a_ns[i]) begin
          if (ns_cnt[i] < 16) idx_log[i][ns_cnt[i]] = a_idx[i];
          ns_cnt[i]++;
        end
        if (a_act[i] && tick && !pause) eff[i][a_note[i]]++;
        if (a_act[i] && a_note[i] != 4'd0) nz[i]++;
      end

  initial forever begin
    @(posedge clk);
    #3;
    cyc++;
    tick  = tick_mode == 1 ? (cyc % 4 == 0) : tick_mode == 2 ? ($urandom_range(0, 1) == 1) : 1'b0;
    pause = tick_mode == 2 ? ($urandom_range(0, 7) == 0) : pause_req;
  end

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    cycles(1);
    clr_mon = 1'b0;
  endtask

  task automatic fill(logic [15:0] v);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) rom[i][k] = v;
  endtask

  task automatic set_both(int k, logic [15:0] v);
    rom[0][k] = v;
    rom[1][k] = v;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!(done_a && done_b) && n < 3000) begin
      cycles(1);
      n++;
    end
    compared++;
    if (!(done_a && done_b)) begin
      mismatched++;
      $display("FAIL %s_timeout: song_done a=%0b b=%0b, required 1", name, done_a, done_b);
    end
  endtask

  task automatic wait_note(string name);
    int n = 0;
    while (ns_cnt[0] == 0 && n < 50) begin
      cycles(1);
      n++;
    end
    chk({name, "_note_seen"}, ns_cnt[0] > 0 ? 1 : 0, 1);
  endtask

  initial begin
    fill(16'h0000);
    cycles(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_note", a_note[i], 0);
      chk("rst_busy", a_busy[i], 0);
      chk("rst_done", a_done[i], 0);
    end
    reset_n = 1'b1;
    cycles(2);

    // C for 3 ticks, E for 2, then the end marker
    set_both(0, 16'h1003);
    set_both(1, 16'h5002);
    tick_mode = 1;
    clear_mon();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("t1_busy_after_start", busy_a, 1);
    cycles(1);
    chk("t1_no_pulse_in_wait", bus_a.note_start, 0);
    cycles(1);
    chk("t1_start_latency", bus_a.note_start, 1);
    chk("t1_first_note", bus_a.correct_note, 1);
    wait_done("t1");
    for (int i = 0; i < 2; i++) begin
      chk("t1_pulses", ns_cnt[i], 2);
      chk("t1_c_ticks", eff[i][1], 3);
      chk("t1_e_ticks", eff[i][5], 2);
      chk("t1_idx0", idx_log[i][0], 0);
      chk("t1_idx1", idx_log[i][1], 1);
      chk("t1_note_z", a_note[i], 0);
    end

    // pause mid-note for 10 tick periods
    fill(16'h0000);
    set_both(0, 16'h1008);
    clear_mon();
    pulse_start();
    wait_note("t2");
    cycles(9);
    pause_req = 1'b1;
    cycles(40);
    chk("t2_paused_note", bus_a.correct_note, 1);
    chk("t2_paused_active", bus_a.note_active, 1);
    pause_req = 1'b0;
    wait_done("t2");
    chk("t2_ticks_a", eff[0][1], 8);
    chk("t2_ticks_b", eff[1][1], 8);

    // unused and out-of-range note codes play as rests
    fill(16'h0000);
    set_both(0, 16'h6002);
    set_both(1, 16'hf001);
    clear_mon();
    pulse_start();
    wait_done("t3");
    for (int i = 0; i < 2; i++) begin
      chk("t3_pulses", ns_cnt[i], 2);
      chk("t3_z_ticks", eff[i][0], 3);
      chk("t3_nonz", nz[i], 0);
    end

    // no end marker: the 2-bit instance stops at address 3
    fill(16'h9001);
    rom[0][4] = 16'h0000;
    clear_mon();
    pulse_start();
    wait_done("t4");
    chk("t4_addr_b", a_addr[1], 3);
    chk("t4_addr_a", a_addr[0], 4);
    chk("t4_pulses_b", ns_cnt[1], 4);
    chk("t4_g_ticks_b", eff[1][9], 4);
    chk("t4_idx3_b", idx_log[1][3], 3);

    // start during PLAY is ignored; reset mid-note clears everything at once
    fill(16'h0000);
    set_both(0, 16'h1005);
    clear_mon();
    pulse_start();
    wait_note("t5");
    cycles(2);
    pulse_start();
    cycles(2);
    chk("t5_playing", bus_a.correct_note, 1);
    chk("t5_one_pulse", ns_cnt[0], 1);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_rst_note", a_note[i], 0);
      chk("t5_rst_active", a_act[i], 0);
      chk("t5_rst_busy", a_busy[i], 0);
      chk("t5_rst_idx", a_idx[i], 0);
      chk("t5_rst_addr", a_addr[i], 0);
    end
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    clear_mon();
    pulse_start();
    wait_done("t5");
    chk("t5_replay_pulses", ns_cnt[0], 1);
    chk("t5_replay_idx", idx_log[0][0], 0);
    chk("t5_replay_ticks", eff[0][1], 5);

    // randomized songs, ticks, pauses, stray starts and occasional resets
    tick_mode = 2;
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 16; k++)
          rom[i][k] = {4'($urandom_range(0, 15)),
                       $urandom_range(0, 5) == 0 ? 12'd0 : 12'($urandom_range(1, 3))};
      rom[0][16] = 16'h0000;
      pulse_start();
      cycles($urandom_range(3, 30));
      if (s % 10 == 5) begin
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
      end else begin
        if ($urandom_range(0, 1) == 1) pulse_start();
        wait_done("rand");
      end
    end
    tick_mode = 0;
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
